// File: rtl/rename_regfile_pkg.sv
// rtl/rename_regfile_pkg.sv - shared defaults and the None tag for the rename register file
package rename_regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREG_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned TAG_W_DEF  = 4;
  localparam int unsigned N_READ_DEF = 2;

  // Tag value 0 means "no pending producer"; the value lives in the data array.
  localparam int unsigned TAG_NONE = 0;

endpackage

// File: rtl/rename_regfile_rf_read_port.sv
// rtl/rename_regfile_rf_read_port.sv - one combinational read port with commit bypass
module rf_read_port
  import rename_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [TAG_W-1:0]  reg_tag,
  input  logic              cmt_valid,
  input  logic [TAG_W-1:0]  cmt_tag,
  input  logic [XLEN-1:0]   cmt_data,
  output logic [XLEN-1:0]   val_out,
  output logic [TAG_W-1:0]  tag_out
);

  logic pending;
  assign pending = (reg_tag != TAG_W'(TAG_NONE));

  always_comb begin
    val_out = '0;
    tag_out = TAG_W'(TAG_NONE);
    if (rs_addr == '0) begin
      val_out = '0;
    end else if (cmt_valid && pending && (reg_tag == cmt_tag)) begin
      // Producer is committing right now: forward its result, not gated by pause or flush.
      val_out = cmt_data;
    end else if (!pending) begin
      val_out = reg_data;
    end else begin
      tag_out = reg_tag;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with per-register ROB rename tags
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int N_READ = N_READ_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     iss_valid_in,
  input  logic [REG_AW-1:0]        iss_rd_in,
  input  logic [TAG_W-1:0]         iss_tag_in,
  input  logic                     cmt_valid_in,
  input  logic [REG_AW-1:0]        cmt_rd_in,
  input  logic [TAG_W-1:0]         cmt_tag_in,
  input  logic [XLEN-1:0]          cmt_data_in,
  input  logic [N_READ*REG_AW-1:0] rs_in,
  output logic [N_READ*XLEN-1:0]   rs_val_out,
  output logic [N_READ*TAG_W-1:0]  rs_tag_out,
  output logic [REG_AW:0]          busy_cnt_out
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [XLEN-1:0]  data_d [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (rdy_in) begin
      // Commit is in order, so its data always lands; only a matching tag is retired.
      if (cmt_valid_in && (cmt_rd_in != '0)) begin
        data_d[cmt_rd_in] = cmt_data_in;
        if (tag_q[cmt_rd_in] == cmt_tag_in) begin
          tag_d[cmt_rd_in] = TAG_W'(TAG_NONE);
        end
      end
      if (flush_in) begin
        for (int i = 0; i < NREG; i++) begin
          tag_d[i] = TAG_W'(TAG_NONE);
        end
      end else if (iss_valid_in && (iss_rd_in != '0)) begin
        tag_d[iss_rd_in] = iss_tag_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= TAG_W'(TAG_NONE);
      end
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    logic [REG_AW-1:0] addr;
    assign addr = rs_in[p*REG_AW +: REG_AW];

    rf_read_port #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .TAG_W  (TAG_W)
    ) u_port (
      .rs_addr   (addr),
      .reg_data  (data_q[addr]),
      .reg_tag   (tag_q[addr]),
      .cmt_valid (cmt_valid_in),
      .cmt_tag   (cmt_tag_in),
      .cmt_data  (cmt_data_in),
      .val_out   (rs_val_out[p*XLEN +: XLEN]),
      .tag_out   (rs_tag_out[p*TAG_W +: TAG_W])
    );
  end

  always_comb begin
    busy_cnt_out = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_cnt_out = busy_cnt_out + (REG_AW+1)'(tag_q[i] != TAG_W'(TAG_NONE));
    end
  end

  always @(posedge clk_in) begin
    if (rst_n_in && rdy_in && iss_valid_in && !flush_in && (iss_rd_in != '0)) begin
      assert (iss_tag_in != TAG_W'(TAG_NONE));
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// tb/tb_rename_regfile.sv - scoreboard bench for rename_regfile against an array reference model
module tb_rename_regfile;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, flush_in;
  logic        iss_valid_in, cmt_valid_in;
  logic [4:0]  iss_rd_in, cmt_rd_in;
  logic [3:0]  iss_tag_in, cmt_tag_in;
  logic [31:0] cmt_data_in;
  logic [9:0]  rs_in;
  logic [63:0] rs_val_out;
  logic [7:0]  rs_tag_out;
  logic [5:0]  busy_cnt_out;

  always #5 clk_in = ~clk_in;

  rename_regfile dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .flush_in     (flush_in),
    .iss_valid_in (iss_valid_in),
    .iss_rd_in    (iss_rd_in),
    .iss_tag_in   (iss_tag_in),
    .cmt_valid_in (cmt_valid_in),
    .cmt_rd_in    (cmt_rd_in),
    .cmt_tag_in   (cmt_tag_in),
    .cmt_data_in  (cmt_data_in),
    .rs_in        (rs_in),
    .rs_val_out   (rs_val_out),
    .rs_tag_out   (rs_tag_out),
    .busy_cnt_out (busy_cnt_out)
  );

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [3:0]  t0;
    logic [3:0]  t1;
    logic [5:0]  busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_data [32];
  logic [3:0]  m_tag  [32];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 32'h0;
      m_tag[i]  = 4'h0;
    end
  endtask

  // State change caused by the edge that just passed, using the inputs held across it.
  task automatic model_edge();
    if (rst_n_in && rdy_in) begin
      if (cmt_valid_in && cmt_rd_in != 0) begin
        m_data[cmt_rd_in] = cmt_data_in;
        if (m_tag[cmt_rd_in] == cmt_tag_in) m_tag[cmt_rd_in] = 4'h0;
      end
      if (flush_in) begin
        for (int i = 0; i < 32; i++) m_tag[i] = 4'h0;
      end else if (iss_valid_in && iss_rd_in != 0) begin
        m_tag[iss_rd_in] = iss_tag_in;
      end
    end
  endtask

  task automatic model_read(input logic [4:0] r, output logic [31:0] v, output logic [3:0] t);
    v = 32'h0;
    t = 4'h0;
    if (r == 0) begin
      v = 32'h0;
    end else if (m_tag[r] == 0) begin
      v = m_data[r];
    end else if (cmt_valid_in && cmt_tag_in == m_tag[r]) begin
      v = cmt_data_in;
    end else begin
      t = m_tag[r];
    end
  endtask

  task automatic push_expect();
    exp_t e;
    int   cnt;
    model_read(rs_in[4:0], e.v0, e.t0);
    model_read(rs_in[9:5], e.v1, e.t1);
    cnt = 0;
    for (int i = 0; i < 32; i++) if (m_tag[i] != 0) cnt++;
    e.busy = 6'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic rst, input logic rdy, input logic fl,
                       input logic iv, input logic [4:0] ird, input logic [3:0] itag,
                       input logic cv, input logic [4:0] crd, input logic [3:0] ctag,
                       input logic [31:0] cdata, input logic [4:0] r0, input logic [4:0] r1);
    @(posedge clk_in);
    #1;
    model_edge();
    rst_n_in     = rst;
    rdy_in       = rdy;
    flush_in     = fl;
    iss_valid_in = iv;
    iss_rd_in    = ird;
    iss_tag_in   = itag;
    cmt_valid_in = cv;
    cmt_rd_in    = crd;
    cmt_tag_in   = ctag;
    cmt_data_in  = cdata;
    rs_in        = {r1, r0};
    if (!rst) model_reset();
    #1;
    push_expect();
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    apply(1, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, r0, r1);
  endtask

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rs_val0", rs_val_out[31:0], e.v0);
      chk("rs_val1", rs_val_out[63:32], e.v1);
      chk("rs_tag0", 32'(rs_tag_out[3:0]), 32'(e.t0));
      chk("rs_tag1", 32'(rs_tag_out[7:4]), 32'(e.t1));
      chk("busy_cnt", 32'(busy_cnt_out), 32'(e.busy));
    end
  end

  task automatic random_cycles(input int n);
    logic [4:0] crd, r0, r1;
    logic [3:0] ctag;
    for (int k = 0; k < n; k++) begin
      crd  = 5'($urandom_range(0, 31));
      ctag = (($urandom % 4) != 0 && m_tag[crd] != 0) ? m_tag[crd] : 4'($urandom_range(1, 15));
      r0   = 5'($urandom_range(0, 31));
      r1   = (($urandom % 2) == 0) ? crd : 5'($urandom_range(0, 31));
      apply(1, ($urandom % 8) != 0, ($urandom % 16) == 0,
            1'($urandom), 5'($urandom_range(0, 31)), 4'($urandom_range(1, 15)),
            1'($urandom), crd, ctag, $urandom, r0, r1);
    end
  endtask

  initial begin
    rst_n_in = 0; rdy_in = 1; flush_in = 0;
    iss_valid_in = 0; iss_rd_in = 0; iss_tag_in = 1;
    cmt_valid_in = 0; cmt_rd_in = 0; cmt_tag_in = 0; cmt_data_in = 0;
    rs_in = 0;
    model_reset();

    apply(0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 5, 7);
    idle(5, 7);

    apply(1, 1, 0, 1, 5, 3, 0, 0, 0, 32'h0, 5, 0);
    idle(5, 0);
    apply(1, 1, 0, 0, 0, 1, 1, 5, 3, 32'hDEADBEEF, 5, 5);
    idle(5, 0);

    apply(1, 1, 0, 1, 7, 2, 0, 0, 0, 32'h0, 7, 5);
    apply(1, 1, 0, 1, 7, 6, 0, 0, 0, 32'h0, 7, 5);
    apply(1, 1, 0, 0, 0, 1, 1, 7, 2, 32'h11, 7, 5);
    idle(7, 5);

    apply(1, 1, 0, 1, 9, 1, 0, 0, 0, 32'h0, 9, 7);
    idle(9, 7);
    apply(1, 1, 0, 1, 9, 4, 1, 9, 1, 32'h55, 9, 7);
    idle(9, 7);
    apply(1, 1, 0, 0, 0, 1, 1, 9, 4, 32'h66, 9, 7);
    idle(9, 7);

    apply(1, 1, 0, 1, 1, 1, 0, 0, 0, 32'h0, 1, 2);
    apply(1, 1, 0, 1, 2, 2, 0, 0, 0, 32'h0, 1, 2);
    apply(1, 1, 0, 1, 3, 3, 0, 0, 0, 32'h0, 3, 2);
    apply(1, 1, 1, 1, 4, 5, 1, 2, 2, 32'hAA, 2, 4);
    idle(2, 4);

    apply(1, 1, 0, 1, 0, 7, 1, 0, 7, 32'hFF, 0, 8);
    idle(0, 8);
    apply(1, 0, 0, 1, 8, 1, 0, 0, 0, 32'h0, 8, 0);
    apply(1, 0, 1, 0, 0, 1, 1, 5, 9, 32'h123, 8, 5);
    idle(8, 0);

    random_cycles(300);
    apply(0, 1, 0, 1, 6, 2, 1, 5, 3, 32'h77, 6, 5);
    idle(6, 5);
    random_cycles(100);

    @(negedge clk_in);
    @(negedge clk_in);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
